// File: rtl/nibble_add_sequencer_if.sv
// Client-side bus of the nibble-serial adder controller: two requesters' operands
// and requests in, ownership/status and the shared registered result out.
interface nibble_add_sequencer_if #(
    parameter int WIDTH = 16
);
    // Handshake: a client holds reqN high until it sees done while gntN is high.
    // It then drops reqN on the edge that ends that done cycle. Operands and cin
    // are sampled only on the edge that raises gntN. sum/cout are valid while done
    // is high, and they hold until the next grant.
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             cin0;
    logic             cin1;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output req0, req1, a0, b0, a1, b1, cin0, cin1,
        input  gnt0, gnt1, busy, done, sum, cout
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, cin0, cin1,
        output gnt0, gnt1, busy, done, sum, cout
    );
endinterface

// File: rtl/nibble_add_sequencer.sv
// Two-client round-robin controller that time-shares one 4-bit ripple-carry slice,
// producing a WIDTH-bit sum least-significant nibble first over WIDTH/4 cycles.
module nibble_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_add_sequencer_if.slave bus,
    output logic [1:0]           fsm_state
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               last;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               gnt0_q;
    logic               gnt1_q;

    logic               grant;
    logic               pick1;
    logic               last_nibble;
    logic [3:0]         nib_s;
    logic               nib_c;
    logic               ripple;

    // Client 1 wins when it is the only requester, or when both request and
    // client 0 was served last.
    always_comb begin
        pick1       = bus.req1 && (!bus.req0 || !last);
        grant       = (state == IDLE) && (bus.req0 || bus.req1);
        last_nibble = (idx == IDX_W'(NIBBLES - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = RUN;
            RUN:     if (last_nibble) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The shared slice: a plain 4-bit full-adder chain fed by the carry register.
    always_comb begin
        nib_s  = '0;
        ripple = carry;
        for (int i = 0; i < 4; i++) begin
            nib_s[i] = op_a[i] ^ op_b[i] ^ ripple;
            ripple   = (op_a[i] & op_b[i]) | (ripple & (op_a[i] ^ op_b[i]));
        end
        nib_c = ripple;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last   <= 1'b1;
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        op_a   <= pick1 ? bus.a1 : bus.a0;
                        op_b   <= pick1 ? bus.b1 : bus.b0;
                        carry  <= pick1 ? bus.cin1 : bus.cin0;
                        idx    <= '0;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        gnt0_q <= !pick1;
                        gnt1_q <= pick1;
                        last   <= pick1;
                    end
                end
                RUN: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (idx == IDX_W'(n)) sum_q[4*n +: 4] <= nib_s;
                    end
                    carry <= nib_c;
                    op_a  <= op_a >> 4;
                    op_b  <= op_b >> 4;
                    idx   <= idx + IDX_W'(1);
                    if (last_nibble) cout_q <= nib_c;
                end
                DONE: begin
                    gnt0_q <= 1'b0;
                    gnt1_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt0  = gnt0_q;
    assign bus.gnt1  = gnt1_q;
    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign fsm_state = state;
endmodule
